// File: rtl/uart_rx_fifo_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } rx_state_t;

    localparam int DEFAULT_CLKS_PER_BIT = 4167;
    localparam int UART_DATA_BITS       = 8;

endpackage

// File: rtl/uart_rx_fifo_sync_fifo.sv
// Single-clock show-ahead FIFO; a push while full is accepted only when a pop
// frees an entry in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt_q;
    logic             do_push;
    logic             do_pop;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign count   = cnt_q;
    assign rdata   = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointer width equals log2(DEPTH), so wrap-around is the natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a show-ahead byte FIFO, with sticky framing and
// overrun flags and a level interrupt.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 8,
    parameter int IRQ_LEVEL    = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          rx_i,
    output logic [7:0]                    m_data,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          frame_err,
    output logic                          overrun,
    input  logic                          clear_i,
    output logic                          irq,
    output logic                          busy
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [15:0]   HALF_BIT = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0]   FULL_BIT = 16'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    LAST_BIT = 3'(UART_DATA_BITS - 1);
    localparam logic [CW-1:0] IRQ_THR  = CW'(IRQ_LEVEL);

    rx_state_t   state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic        rx_meta, rx_sync, rx_d;
    logic        push_byte;
    logic        frame_set;
    logic        fifo_full;
    logic        fifo_empty;
    logic        overrun_set;

    // Synchronizer and edge-detect history preset to the idle line level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_d    <= 1'b1;
        end else begin
            rx_meta <= rx_i;
            rx_sync <= rx_meta;
            rx_d    <= rx_sync;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

    // The baud counter restarts from zero on every state change.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 16'd1;
        bit_d     = bit_q;
        shift_d   = shift_q;
        push_byte = 1'b0;
        frame_set = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (rx_d && !rx_sync) begin
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == HALF_BIT) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rx_sync ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt_q == FULL_BIT) begin
                    cnt_d   = '0;
                    shift_d = {rx_sync, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == LAST_BIT) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (cnt_q == FULL_BIT) begin
                    cnt_d = '0;
                    if (rx_sync) begin
                        push_byte = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        frame_set = 1'b1;
                        state_d   = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                cnt_d = '0;
                if (rx_sync) begin
                    state_d = IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // Consumer handshake: the head byte on m_data transfers on any rising clock
    // edge where m_valid && m_ready; m_data is stable while m_valid waits.
    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_byte),
        .wdata (shift_q),
        .pop   (m_ready),
        .rdata (m_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (count)
    );

    assign m_valid     = ~fifo_empty;
    assign overrun_set = push_byte & fifo_full & ~(m_valid & m_ready);

    // A new error event in the same cycle as clear_i keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= (frame_err & ~clear_i) | frame_set;
            overrun   <= (overrun & ~clear_i) | overrun_set;
        end
    end

    assign irq  = (count >= IRQ_THR) | overrun;
    assign busy = (state_q != IDLE);

endmodule
